gray_sweep_ctrl: RTL

Sequencer that drives the team's binary-to-Gray converter through a programmed range of binary codes. It presents one converted code per accepted beat on a valid/ready stream. It sits between a test or control host, which issues start/abort, and any Gray-code consumer: encoder emulation, counter checking, or self-test of the combinational converter. It also carries a built-in single-bit-change checker on the emitted stream.

---
 rtl/gray_sweep_if.sv | 32 +++
 rtl/gray_sweep_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/gray_sweep_if.sv
// Bundle of the sweep controller's control inputs and the Gray-code output stream.
// Stream handshake: a beat moves on a rising edge where out_valid and out_ready
// are both high; while out_valid is high and out_ready low the producer holds
// out_bin/out_gray unchanged, and out_valid only drops after a transfer (or on abort/reset).
interface gray_sweep_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] last;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic [WIDTH-1:0] out_gray;
  logic             busy;
  logic             done;
  logic             step_err;

  // Sequencer side: drives the stream and status.
  modport master (
    input  start, dir, first, last, abort, out_ready,
    output out_valid, out_bin, out_gray, busy, done, step_err
  );

  // Host / consumer side.
  modport slave (
    output start, dir, first, last, abort, out_ready,
    input  out_valid, out_bin, out_gray, busy, done, step_err
  );
endinterface

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary index from first to last (up or down, wrapping modulo 2^WIDTH),
// presenting each index and its Gray code as one stream beat, and flags any pair
// of consecutively transferred Gray codes that differ in other than exactly one bit.
module gray_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_sweep_if.master  bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_dir;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] r_bin;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_step_err;
  logic             r_have_prev;
  logic [WIDTH-1:0] r_prev_gray;

  logic             w_xfer;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_step;
  logic             w_step_ok;

  // Transfer, next index and single-bit-change test on the code actually presented.
  assign w_xfer     = r_valid & bus.out_ready;
  assign w_next_bin = r_dir ? (r_bin - ONE) : (r_bin + ONE);
  assign w_step     = bus.out_gray ^ r_prev_gray;
  assign w_step_ok  = (w_step != '0) && ((w_step & (w_step - ONE)) == '0);

  // Gray code is a pure function of the registered index.
  assign bus.out_gray  = r_bin ^ (r_bin >> 1);
  assign bus.out_bin   = r_bin;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.step_err  = r_step_err;
  assign o_dbg_state   = r_state;

  // Sweep FSM with registered stream/status outputs and the step checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_last      <= '0;
      r_bin       <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_step_err  <= 1'b0;
      r_have_prev <= 1'b0;
      r_prev_gray <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state     <= S_RUN;
            r_dir       <= bus.dir;
            r_last      <= bus.last;
            r_bin       <= bus.first;
            r_valid     <= 1'b1;
            r_busy      <= 1'b1;
            r_step_err  <= 1'b0;
            r_have_prev <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort wins over a transfer that would complete the sweep.
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (r_have_prev && !w_step_ok) begin
              r_step_err <= 1'b1;
            end
            r_prev_gray <= bus.out_gray;
            r_have_prev <= 1'b1;
            if (r_bin == r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bin <= w_next_bin;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
